// File: rtl/map_ss_engine.sv
// map_ss_engine
//   Save-state initiator between the menu/save-state controller and a mapper.
//   Save: walks mapper registers 0..REG_CNT-1 and then the map-index slot.
//   For each slot it reads ss_rdat and writes that byte to a state buffer.
//   Load: compares the stored map index with the live mapper. On a match it
//   replays the buffered register bytes into the mapper, one write per M2
//   falling edge.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   start_save, start_load    one-clock operation requests (save wins a tie)
//   m2_fall                   one-clock pulse per mapper M2 falling edge
//   ss_act, ss_we             save-state mode / register write strobe to mapper
//   ss_addr, ss_wdat          mapper register index / write data
//   ss_rdat                   mapper readback (combinational from ss_addr)
//   mem_req, mem_we           buffer request (held until mem_ack) / direction
//   mem_addr, mem_dout        buffer byte address (= ss_addr) / write data
//   mem_din, mem_ack          buffer read data / one-clock completion
//   busy, done, err           in progress / success pulse / sticky idx mismatch
module map_ss_engine #(
  parameter int REG_CNT  = 3,
  parameter int IDX_ADDR = 127,
  parameter int SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_save,
  input  logic       start_load,
  input  logic       m2_fall,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_dout,
  input  logic [7:0] mem_din,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] IDX_A       = 8'(IDX_ADDR);
  localparam logic [7:0] LAST_REG    = 8'(REG_CNT - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SV_SET,
    S_SV_MEM,
    S_LD_IDX,
    S_LD_CMP,
    S_LD_RD,
    S_LD_ARM,
    S_LD_REL,
    S_FIN
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] slot;
  logic [3:0] settle_cnt;
  logic       armed;
  logic [7:0] idx_buf;
  logic       settle_done;
  logic       idx_match;

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign idx_match   = (idx_buf == ss_rdat);
  assign mem_addr    = ss_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Outputs are decoded from the state, so a reset drops ss_act, ss_we and
  // mem_req on the very edge that samples rst.
  always_comb begin
    state_nxt = state;
    ss_act    = 1'b1;
    ss_we     = 1'b0;
    ss_addr   = slot;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ss_act  = 1'b0;
        ss_addr = 8'h00;
        busy    = 1'b0;
        if (start_save)      state_nxt = S_SV_SET;
        else if (start_load) state_nxt = S_LD_IDX;
      end
      S_SV_SET: begin
        if (settle_done) state_nxt = S_SV_MEM;
      end
      S_SV_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_nxt = (slot == IDX_A) ? S_FIN : S_SV_SET;
      end
      S_LD_IDX: begin
        ss_addr = IDX_A;
        mem_req = 1'b1;
        if (mem_ack) state_nxt = S_LD_CMP;
      end
      S_LD_CMP: begin
        ss_addr = IDX_A;
        if (settle_done) state_nxt = idx_match ? S_LD_RD : S_IDLE;
      end
      S_LD_RD: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = S_LD_ARM;
      end
      S_LD_ARM: begin
        ss_we = 1'b1;
        // The first ARM clock is setup time: an M2 edge seen then is too
        // early to latch the data the mapper has just been handed.
        if (armed && m2_fall) state_nxt = S_LD_REL;
      end
      S_LD_REL: begin
        state_nxt = (slot == LAST_REG) ? S_FIN : S_LD_RD;
      end
      S_FIN: begin
        ss_act    = 1'b0;
        ss_addr   = 8'h00;
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        ss_act    = 1'b0;
        ss_addr   = 8'h00;
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot       <= 8'h00;
      settle_cnt <= 4'h0;
      armed      <= 1'b0;
      idx_buf    <= 8'h00;
      mem_dout   <= 8'h00;
      ss_wdat    <= 8'h00;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          settle_cnt <= 4'h0;
          armed      <= 1'b0;
          if (start_save || start_load) begin
            err  <= 1'b0;
            slot <= 8'h00;
          end
        end
        S_SV_SET: begin
          settle_cnt <= settle_done ? 4'h0 : settle_cnt + 4'h1;
          if (settle_done) mem_dout <= ss_rdat;
        end
        S_SV_MEM: begin
          // After the last register the walk jumps to the map-index slot.
          if (mem_ack) slot <= (slot == LAST_REG) ? IDX_A : slot + 8'h01;
        end
        S_LD_IDX: begin
          if (mem_ack) idx_buf <= mem_din;
        end
        S_LD_CMP: begin
          settle_cnt <= settle_done ? 4'h0 : settle_cnt + 4'h1;
          if (settle_done && !idx_match) err <= 1'b1;
        end
        S_LD_RD: begin
          if (mem_ack) begin
            ss_wdat <= mem_din;
            armed   <= 1'b0;
          end
        end
        S_LD_ARM: begin
          armed <= 1'b1;
        end
        S_LD_REL: begin
          slot <= slot + 8'h01;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_ss_engine.sv
// tb_map_ss_engine
//   Directed bench for map_ss_engine. It models the mapper register file and
//   the state buffer, which answers with mem_ack one clock after it sees a
//   request. It also models an M2 edge source. Bench inputs change and
//   outputs are observed at the falling clock edge.
module tb_map_ss_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_save = 1'b0;
  logic       start_load = 1'b0;
  logic       m2_fall = 1'b0;
  logic       ss_act, ss_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_dout;
  logic [7:0] mem_din = 8'h00;
  logic       mem_ack = 1'b0;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mapper_reg [0:255];
  logic [7:0] bufmem     [0:255];

  assign ss_rdat = mapper_reg[ss_addr];

  always #5 clk = ~clk;

  map_ss_engine #(.REG_CNT(3), .IDX_ADDR(127), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start_save(start_save), .start_load(start_load),
    .m2_fall(m2_fall), .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
    .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  // Environment: buffer responder, M2 source and monitors.
  int         m2_mode = 0;   // 0 none, 1 every 12 clocks, 2 on ss_we rise and 4 clocks later
  int         m2_cnt = 0;
  int         age = 0;
  logic       req_seen = 1'b0;
  logic       prev_we = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [7:0] prev_wdat = 8'h00;
  int         cur_len = 0;
  int         we_pulses = 0, m2_used = 0, done_cnt = 0, act_gap = 0, stab_err = 0;
  logic [7:0] mw_addr[$], mw_data[$], bw_addr[$], bw_data[$];
  int         we_len[$];

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  = 1'b0;
      req_seen = 1'b0;
    end else if (mem_req) begin
      if (req_seen) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          bufmem[mem_addr] = mem_dout;
          bw_addr.push_back(mem_addr);
          bw_data.push_back(mem_dout);
        end else begin
          mem_din = bufmem[mem_addr];
        end
      end else begin
        req_seen = 1'b1;
      end
    end else begin
      req_seen = 1'b0;
    end

    if (m2_mode == 1) begin
      m2_cnt++;
      m2_fall = (m2_cnt % 12 == 0);
    end else if (m2_mode == 2) begin
      if (ss_we && !prev_we) age = 0;
      else if (ss_we) age++;
      m2_fall = ss_we && (age == 0 || age == 4);
    end else begin
      m2_fall = 1'b0;
    end

    if (ss_we && prev_we && m2_fall) begin
      m2_used++;
      mw_addr.push_back(ss_addr);
      mw_data.push_back(ss_wdat);
    end
    if (ss_we && !prev_we) begin
      we_pulses++;
      cur_len = 1;
    end else if (ss_we) begin
      cur_len++;
      if (ss_addr != prev_addr || ss_wdat != prev_wdat) stab_err++;
    end else if (prev_we) begin
      we_len.push_back(cur_len);
    end
    if (done) done_cnt++;
    if (busy && !ss_act) act_gap++;
    prev_we   = ss_we;
    prev_addr = ss_addr;
    prev_wdat = ss_wdat;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_pulses = 0; m2_used = 0; done_cnt = 0; act_gap = 0; stab_err = 0;
    mw_addr.delete(); mw_data.delete(); bw_addr.delete(); bw_data.delete();
    we_len.delete();
  endtask

  task automatic pulse_start(input logic s, input logic l);
    start_save = s;
    start_load = l;
    tick();
    start_save = 1'b0;
    start_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b required 0 after %0d clocks", name, busy, budget);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({ss_act, ss_we, mem_req, mem_we, busy, done, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {ss_act, ss_we, mem_req, mem_we, busy, done, err});
    end
    checks++;
    if (ss_addr !== 8'h00 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_addr: ss_addr=%h mem_addr=%h required 00", ss_addr, mem_addr);
    end
    checks++;
    if (ss_wdat !== 8'h00 || mem_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: ss_wdat=%h mem_dout=%h required 00", ss_wdat, mem_dout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_save();
    logic [7:0] ea[4] = '{8'h00, 8'h01, 8'h02, 8'h7F};
    logic [7:0] ed[4] = '{8'h0A, 8'h34, 8'h85, 8'h32};
    mapper_reg[0] = 8'h0A; mapper_reg[1] = 8'h34; mapper_reg[2] = 8'h85;
    mapper_reg[127] = 8'h32;
    clear_logs();
    pulse_start(1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || ss_act !== 1'b1) begin
      errors++;
      $display("FAIL save_start: busy=%b ss_act=%b required 1 1", busy, ss_act);
    end
    wait_idle(300, "save");
    checks++;
    if (bw_addr.size() != 4) begin
      errors++;
      $display("FAIL save_count: got %0d buffer writes required 4", bw_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ga, gd;
      ga = (i < bw_addr.size()) ? bw_addr[i] : 8'hxx;
      gd = (i < bw_data.size()) ? bw_data[i] : 8'hxx;
      checks++;
      if (ga !== ea[i] || gd !== ed[i]) begin
        errors++;
        $display("FAIL save_write%0d: got (%h,%h) required (%h,%h)", i, ga, gd, ea[i], ed[i]);
      end
    end
    checks++;
    if (we_pulses != 0) begin
      errors++;
      $display("FAIL save_no_we: got %0d ss_we pulses required 0", we_pulses);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || ss_act !== 1'b0) begin
      errors++;
      $display("FAIL save_end: done_cnt=%0d busy=%b ss_act=%b required 1 0 0", done_cnt, busy, ss_act);
    end
  endtask

  task automatic run_load_checks(input string name, input int req_len);
    logic [7:0] ed[3] = '{8'h05, 8'h10, 8'h9F};
    checks++;
    if (we_pulses != 3 || m2_used != 3) begin
      errors++;
      $display("FAIL %s_pulses: we_pulses=%0d m2_used=%0d required 3 3", name, we_pulses, m2_used);
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ga, gd;
      ga = (i < mw_addr.size()) ? mw_addr[i] : 8'hxx;
      gd = (i < mw_data.size()) ? mw_data[i] : 8'hxx;
      checks++;
      if (ga !== 8'(i) || gd !== ed[i]) begin
        errors++;
        $display("FAIL %s_write%0d: got (%h,%h) required (%h,%h)", name, i, ga, gd, 8'(i), ed[i]);
      end
    end
    if (req_len > 0) begin
      for (int i = 0; i < 3; i++) begin
        int gl;
        gl = (i < we_len.size()) ? we_len[i] : -1;
        checks++;
        if (gl != req_len) begin
          errors++;
          $display("FAIL %s_we_len%0d: got %0d clocks required %0d", name, i, gl, req_len);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0 || act_gap != 0 || stab_err != 0) begin
      errors++;
      $display("FAIL %s_end: done_cnt=%0d err=%b act_gap=%0d stab_err=%0d required 1 0 0 0",
               name, done_cnt, err, act_gap, stab_err);
    end
  endtask

  task automatic load_buffer(input logic [7:0] idx);
    bufmem[0] = 8'h05; bufmem[1] = 8'h10; bufmem[2] = 8'h9F; bufmem[127] = idx;
    mapper_reg[127] = 8'h32;
  endtask

  task automatic test_load_ok();
    load_buffer(8'h32);
    m2_mode = 1;
    clear_logs();
    pulse_start(1'b0, 1'b1);
    checks++;
    if (ss_addr !== 8'h7F || mem_req !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL load_idx_read: ss_addr=%h mem_req=%b mem_we=%b required 7f 1 0", ss_addr, mem_req, mem_we);
    end
    wait_idle(600, "load");
    run_load_checks("load", 0);
    m2_mode = 0;
  endtask

  task automatic test_load_mismatch();
    load_buffer(8'h31);
    m2_mode = 1;
    clear_logs();
    pulse_start(1'b0, 1'b1);
    wait_idle(200, "mismatch");
    checks++;
    if (err !== 1'b1 || we_pulses != 0 || done_cnt != 0 || ss_act !== 1'b0) begin
      errors++;
      $display("FAIL mismatch: err=%b we_pulses=%0d done_cnt=%0d ss_act=%b required 1 0 0 0",
               err, we_pulses, done_cnt, ss_act);
    end
    m2_mode = 0;
    pulse_start(1'b1, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
    wait_idle(300, "mismatch_save");
  endtask

  task automatic test_setup_ignore();
    load_buffer(8'h32);
    m2_mode = 2;
    clear_logs();
    pulse_start(1'b0, 1'b1);
    wait_idle(600, "setup");
    run_load_checks("setup", 5);
    m2_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load_buffer(8'h32);
    m2_mode = 0;
    pulse_start(1'b0, 1'b1);
    while (!ss_we && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (ss_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_arm: ss_we=%b required 1", ss_we);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ss_we, ss_act, busy, mem_req} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_abort: we/act/busy/req=%b required 0000", {ss_we, ss_act, busy, mem_req});
    end
    rst = 1'b0;
    tick();
    m2_mode = 1;
    clear_logs();
    pulse_start(1'b0, 1'b1);
    wait_idle(600, "rst_reload");
    run_load_checks("rst_reload", 0);
    m2_mode = 0;
  endtask

  task automatic test_back_to_back();
    clear_logs();
    pulse_start(1'b1, 1'b1);
    checks++;
    if (ss_addr !== 8'h00 || mem_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL both_start: ss_addr=%h mem_req=%b busy=%b required 00 0 1", ss_addr, mem_req, busy);
    end
    tick(); tick(); tick(); tick();
    pulse_start(1'b0, 1'b1);
    wait_idle(300, "both");
    checks++;
    if (bw_addr.size() != 4 || done_cnt != 1 || we_pulses != 0) begin
      errors++;
      $display("FAIL both_save: writes=%0d done_cnt=%0d we_pulses=%0d required 4 1 0",
               bw_addr.size(), done_cnt, we_pulses);
    end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start_ignored: busy=%b done_cnt=%0d required 0 1", busy, done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mapper_reg[i] = 8'h00;
      bufmem[i] = 8'h00;
    end
    test_reset();
    test_save();
    test_load_ok();
    test_load_mismatch();
    test_setup_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/map_ss_engine.md
Name: map_ss_engine

Overview:
- Save-state initiator that drives the mapper save-state port (ss_act/ss_we/ss_addr/data) from the system side.
- Save: walks mapper registers 0..REG_CNT-1 plus the map-index slot, reads each ss_rdat byte and writes it to a state buffer.
- Load: checks the stored map index against the live mapper, then replays the buffered bytes into the mapper. Each write is aligned to a mapper M2 falling edge.
- Sits between the menu/save-state controller and the mapper instance.

Parameters:
REG_CNT, 3, number of mapper state registers (ss_addr 0..REG_CNT-1)
IDX_ADDR, 127, ss_addr of the read-only map-index byte
SETTLE, 2, clocks ss_addr is held before ss_rdat is sampled (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_save  in  1  one-clock request to begin save
start_load  in  1  one-clock request to begin load
m2_fall  in  1  one-clock pulse per M2 falling edge, synchronised to clk
ss_act  out  1  save-state mode to mapper; freezes normal mapper updates
ss_we  out  1  mapper register write strobe
ss_addr  out  8  mapper state register index
ss_wdat  out  8  data presented to mapper during load (cpu_dat mux)
ss_rdat  in  8  mapper readback, combinational from ss_addr
mem_req  out  1  buffer access request, held until mem_ack
mem_we  out  1  1 = buffer write; valid while mem_req
mem_addr  out  8  buffer byte address (equals ss_addr slot)
mem_dout  out  8  buffer write data
mem_din  in  8  buffer read data, valid in the mem_ack cycle
mem_ack  in  1  one-clock completion of the current request
busy  out  1  operation in progress
done  out  1  one-clock pulse on successful completion
err  out  1  sticky map-index mismatch; cleared by next start or rst

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE. Reset mid-operation aborts immediately: ss_act and ss_we drop in the same cycle rst is sampled, and any pending mem_req is dropped.
- IDLE:
  - start_save -> SV_SET; start_load -> LD_IDX.
  - Both asserted together: save wins.
  - Starts while busy are ignored.
  - Any accepted start clears err, sets busy, sets ss_act.
- Slot sequence: 0, 1, ..., REG_CNT-1, then IDX_ADDR (save only). mem_addr = ss_addr in all states.
- Save path:
  - SV_SET: drive ss_addr; count SETTLE clocks, then latch ss_rdat into mem_dout -> SV_MEM.
  - SV_MEM: mem_req=1, mem_we=1 until mem_ack. On ack, advance slot -> SV_SET; after IDX_ADDR -> FIN.
  - ss_we stays 0 throughout save.
- Load path:
  - LD_IDX: ss_addr=IDX_ADDR, buffer read of IDX_ADDR (mem_we=0). On mem_ack, wait SETTLE, compare mem_din with ss_rdat.
  - Mismatch: err=1, no mapper write, -> IDLE (done stays 0).
  - Match: slot 0 -> LD_RD.
  - LD_RD: buffer read of slot; on ack, latch ss_wdat=mem_din -> LD_ARM.
  - LD_ARM: ss_we=1, ss_addr/ss_wdat stable. Ignore any m2_fall in the first clock of LD_ARM (setup). The first m2_fall after that -> LD_REL.
  - LD_REL: ss_we=0 for one clock, then next slot -> LD_RD. After REG_CNT-1 -> FIN. IDX_ADDR is never written.
- FIN: ss_act=0, busy=0, done=1 for one clock -> IDLE.
- Stability: ss_addr and ss_wdat do not change while ss_we=1. Exactly one m2_fall is consumed per register write.
- No timeout: missing m2_fall or mem_ack stalls with busy=1; only rst recovers.
- mem_ack arriving while mem_req=0 is ignored.
- Width: slot counter is 8 bits. REG_CNT must be less than IDX_ADDR.

Test Plan:
1. Save, REG_CNT=3, mapper returns 0x0A/0x34/0x85 at 0/1/2 and 0x32 at 127, mem_ack 1 clock after each req -> buffer writes (0,0x0A),(1,0x34),(2,0x85),(127,0x32) in order; ss_we never 1; done pulses once; busy low after.
2. Load with buffer {0x05,0x10,0x9F,idx 0x32} and live idx 0x32, m2_fall every 12 clocks -> three ss_we pulses, each spanning exactly one m2_fall, with (addr,data)=(0,0x05),(1,0x10),(2,0x9F); ss_act high throughout; done=1.
3. Load with stored idx 0x31 vs live 0x32 -> err=1, zero ss_we pulses, done=0, ss_act=0. A following save clears err.
4. m2_fall asserted in the same clock ss_we rises -> that edge is ignored; ss_we drops only after the next m2_fall.
5. rst asserted while in LD_ARM with ss_we=1 -> next clock ss_we=0, ss_act=0, busy=0, mem_req=0; a new start_load runs the full sequence from slot 0.
6. start_save and start_load asserted in the same clock -> save sequence runs. A start_load 5 clocks later (engine busy) is ignored; exactly one done pulse.
